serial_subtractor: RTL and testbench

- Bit-serial unsigned subtractor; computes DiffOut = InputA - InputB (mod 2^WIDTH) and BorrowOut = (InputA < InputB).
- Processes one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop.
- Counterpart of the team's adder blocks: the subtract direction, in sequential form, for area-constrained datapaths.
- Start/Busy/Done handshake toward the controlling logic.

---
 rtl/serial_subtractor_pkg.sv | 21 ++
 rtl/serial_subtractor_fs.sv | 17 +
 rtl/serial_subtractor.sv | 133 +++++++++++++
 tb/tb_serial_subtractor.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks (subtractor now,
// adder later): FSM state encoding and the legal operand-width range.
package serial_subtractor_pkg;

    // Handshake FSM states, common to all serial arithmetic units
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } ser_state_e;

    // Legal operand width range
    localparam int SER_WIDTH_MIN = 2;
    localparam int SER_WIDTH_MAX = 32;

    // True when w is a supported operand width
    function automatic bit ser_width_ok(input int w);
        return (w >= SER_WIDTH_MIN) && (w <= SER_WIDTH_MAX);
    endfunction

endpackage

// File: rtl/serial_subtractor_fs.sv
// One-bit full subtractor cell: Diff = A - B - BorrowIn, with the borrow
// out of this bit position.
module full_subtractor (
    input  logic A,
    input  logic B,
    input  logic BorrowIn,
    output logic Diff,
    output logic BorrowOut
);

    // Borrow when B exceeds A, or when A==B and a borrow is already pending
    always_comb begin
        Diff      = A ^ B ^ BorrowIn;
        BorrowOut = (~A & B) | (~(A ^ B) & BorrowIn);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor. Operands are captured on an accepted
// Start, then one bit per clock (LSB first) passes through a single
// full-subtractor cell, with the borrow held in a flip-flop between bits.
// DiffOut/BorrowOut keep the previous result until the new one completes.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] InputA,
    input  logic [WIDTH-1:0] InputB,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] DiffOut,
    output logic             BorrowOut
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    // Elaboration-time guard on the operand width
    if (!ser_width_ok(WIDTH)) begin : g_width_chk
        $error("serial_subtractor: WIDTH must be within 2..32");
    end

    ser_state_e       state_q, state_n;
    logic [WIDTH-1:0] sa_q, sb_q;     // operand shift registers
    logic [WIDTH-1:0] diff_q;         // working difference, fills from MSB
    logic             borrow_q;       // borrow between successive bits
    logic [CNT_W-1:0] cnt_q;          // bit index being processed
    logic [WIDTH-1:0] diff_out_q;
    logic             borrow_out_q;
    logic             busy_q, done_q;

    logic             load, shift_en, finish, last_bit;
    logic             d_bit, b_bit;
    logic [WIDTH-1:0] diff_next;

    assign last_bit  = (cnt_q == CNT_LAST);
    assign diff_next = {d_bit, diff_q[WIDTH-1:1]};

    full_subtractor u_fs (
        .A         (sa_q[0]),
        .B         (sb_q[0]),
        .BorrowIn  (borrow_q),
        .Diff      (d_bit),
        .BorrowOut (b_bit)
    );

    // Next-state and control strobes; Start only matters in IDLE
    always_comb begin
        state_n  = state_q;
        load     = 1'b0;
        shift_en = 1'b0;
        finish   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    state_n = ST_SHIFT;
                    load    = 1'b1;
                end
            end
            ST_SHIFT: begin
                shift_en = 1'b1;
                if (last_bit) begin
                    state_n = ST_DONE;
                    finish  = 1'b1;
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // State register plus registered Busy/Done decoded from the next state
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            busy_q  <= (state_n == ST_SHIFT);
            done_q  <= (state_n == ST_DONE);
        end
    end

    // Serial datapath: capture on load, then one bit per clock
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sa_q     <= '0;
            sb_q     <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
        end else if (load) begin
            sa_q     <= InputA;
            sb_q     <= InputB;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
        end else if (shift_en) begin
            sa_q     <= sa_q >> 1;
            sb_q     <= sb_q >> 1;
            diff_q   <= diff_next;
            borrow_q <= b_bit;
            // Counter is cleared on every load, so it never needs to wrap
            if (!last_bit) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // Result registers only move when the final bit completes
    always_ff @(posedge Clk) begin
        if (Reset) begin
            diff_out_q   <= '0;
            borrow_out_q <= 1'b0;
        end else if (finish) begin
            diff_out_q   <= diff_next;
            borrow_out_q <= b_bit;
        end
    end

    assign Busy      = busy_q;
    assign Done      = done_q;
    assign DiffOut   = diff_out_q;
    assign BorrowOut = borrow_out_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=4): directed cases,
// mid-operation reset, held Start, exhaustive pairs and random operands,
// all checked against plain-arithmetic expectations and cycle timing.
module tb_serial_subtractor;

    localparam int W   = 4;
    localparam int MOD = 1 << W;

    logic         Clk = 1'b0;
    logic         Reset;
    logic         Start;
    logic [W-1:0] InputA, InputB;
    logic         Busy, Done, BorrowOut;
    logic [W-1:0] DiffOut;

    int n_cmp    = 0;
    int n_err    = 0;
    int done_cnt = 0;

    // Currently visible result according to the reference model
    int mdl_diff   = 0;
    int mdl_borrow = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .InputA    (InputA),
        .InputB    (InputB),
        .Busy      (Busy),
        .Done      (Done),
        .DiffOut   (DiffOut),
        .BorrowOut (BorrowOut)
    );

    always #5 Clk = ~Clk;

    // Count Done pulses as seen at each rising edge
    always @(posedge Clk) if (Done === 1'b1) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Runs one operation from a negedge; returns at the negedge after Done drops.
    // hold=1 keeps Start high with junk operands during SHIFT and DONE.
    task automatic do_op(input int a, input int b, input bit hold, input string tag);
        int ed, eb;
        ed = (((a - b) % MOD) + MOD) % MOD;
        eb = (a < b) ? 1 : 0;
        InputA = W'(a);
        InputB = W'(b);
        Start  = 1'b1;
        @(negedge Clk);
        if (hold) begin
            InputA = W'(1);
            InputB = W'(1);
        end else begin
            Start  = 1'b0;
            InputA = W'($urandom_range(MOD - 1));
            InputB = W'($urandom_range(MOD - 1));
        end
        for (int i = 0; i < W; i++) begin
            chk({tag, " busy"}, Busy, 1);
            chk({tag, " done_early"}, Done, 0);
            chk({tag, " diff_held"}, DiffOut, mdl_diff);
            chk({tag, " borrow_held"}, BorrowOut, mdl_borrow);
            @(negedge Clk);
        end
        chk({tag, " done"}, Done, 1);
        chk({tag, " busy_at_done"}, Busy, 0);
        chk({tag, " diff"}, DiffOut, ed);
        chk({tag, " borrow"}, BorrowOut, eb);
        mdl_diff   = ed;
        mdl_borrow = eb;
        @(negedge Clk);
        chk({tag, " done_drop"}, Done, 0);
        chk({tag, " idle_busy"}, Busy, 0);
        chk({tag, " diff_stable"}, DiffOut, ed);
    endtask

    initial begin
        int c0;
        Reset  = 1'b1;
        Start  = 1'b0;
        InputA = '0;
        InputB = '0;
        repeat (2) @(negedge Clk);
        chk("rst busy", Busy, 0);
        chk("rst done", Done, 0);
        chk("rst diff", DiffOut, 0);
        chk("rst borrow", BorrowOut, 0);
        Reset = 1'b0;
        @(negedge Clk);

        // Directed cases
        do_op(9, 3, 1'b0, "a9b3");
        do_op(3, 9, 1'b0, "a3b9");
        do_op(0, 15, 1'b0, "a0b15");
        do_op(15, 15, 1'b0, "a15b15");

        // Start held through SHIFT and DONE: one Done, no re-capture
        c0 = done_cnt;
        do_op(12, 5, 1'b1, "hold");
        chk("hold done_count", done_cnt - c0, 1);
        Start = 1'b0;
        @(negedge Clk);
        chk("hold no_restart", Busy, 0);

        // Previous result of 7 must stay visible until the new Done
        do_op(2, 1, 1'b0, "a2b1");

        // Reset on the second SHIFT edge discards the operation
        c0 = done_cnt;
        InputA = W'(5);
        InputB = W'(2);
        Start  = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        chk("midrst busy", Busy, 0);
        chk("midrst done", Done, 0);
        chk("midrst diff", DiffOut, 0);
        chk("midrst borrow", BorrowOut, 0);
        mdl_diff   = 0;
        mdl_borrow = 0;
        repeat (6) @(negedge Clk);
        chk("midrst no_done", done_cnt - c0, 0);
        do_op(8, 8, 1'b0, "a8b8");

        // Every operand pair, back to back
        c0 = done_cnt;
        for (int a = 0; a < MOD; a++)
            for (int b = 0; b < MOD; b++)
                do_op(a, b, 1'b0, "exh");
        chk("exh done_count", done_cnt - c0, MOD * MOD);

        // Random operands with random idle gaps
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(3)) @(negedge Clk);
            do_op(int'($urandom_range(MOD - 1)), int'($urandom_range(MOD - 1)), 1'b0, "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
